// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitHi,
        StWaitLo
    } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps.
module uart_tx_sched_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_id,
    output logic                 o_any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned w_idx;

    // First set request at or after ptr+1 (mod N) wins; winner of the last frame is searched last.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = (32'(i_ptr) + k) % N;
            if (!o_any && i_req[IW'(w_idx)]) begin
                o_any              = 1'b1;
                o_gnt[IW'(w_idx)]  = 1'b1;
                o_gnt_id           = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters using round-robin arbitration.
// Launches one frame at a time and holds the byte and parity config until BUSY falls.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned TO_CYC = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [BYTE_W*NREQ-1:0]   i_req_data,
    input  logic [NREQ-1:0]          i_req_par_en,
    input  logic [NREQ-1:0]          i_req_par_typ,
    output logic [NREQ-1:0]          o_req_ack,
    input  logic                     i_tx_busy,
    output logic [BYTE_W-1:0]        o_par_data,
    output logic                     o_data_valid,
    output logic                     o_par_en,
    output logic                     o_par_typ,
    output logic [$clog2(NREQ)-1:0]  o_gnt_id,
    output logic                     o_err_to
);

    localparam int unsigned IDW = $clog2(NREQ);
    // Counter only needs to reach TO_CYC-2; the next step raises the timeout.
    localparam int unsigned CW  = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    sched_state_e      r_state;
    logic [CW-1:0]     r_cnt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_gnt_id;
    logic [NREQ-1:0]   r_ack;
    logic [BYTE_W-1:0] r_par_data;
    logic              r_data_valid;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_err_to;

    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_any;
    logic [BYTE_W-1:0] w_sel_data;
    logic              w_sel_par_en;
    logic              w_sel_par_typ;

    uart_tx_sched_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    // Route the winning requester's byte and parity config using the one-hot grant.
    always_comb begin
        w_sel_data    = '0;
        w_sel_par_en  = 1'b0;
        w_sel_par_typ = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data    = i_req_data[i*BYTE_W +: BYTE_W];
                w_sel_par_en  = i_req_par_en[i];
                w_sel_par_typ = i_req_par_typ[i];
            end
        end
    end

    // Scheduler FSM with registered outputs, timeout counter and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_ptr        <= IDW'(NREQ - 1);
            r_gnt_id     <= '0;
            r_ack        <= '0;
            r_par_data   <= '0;
            r_data_valid <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_err_to     <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_data_valid <= 1'b0;
            r_ack        <= '0;
            r_err_to     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!i_tx_busy && w_any) begin
                        r_par_data   <= w_sel_data;
                        r_par_en     <= w_sel_par_en;
                        r_par_typ    <= w_sel_par_typ;
                        r_gnt_id     <= w_gnt_id;
                        r_ack        <= w_gnt;
                        r_data_valid <= 1'b1;
                        r_state      <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_cnt   <= '0;
                    r_state <= StWaitHi;
                end
                StWaitHi: begin
                    if (i_tx_busy) begin
                        r_state <= StWaitLo;
                    end else if (r_cnt == CW'(TO_CYC - 2)) begin
                        // Byte was already acked, so it is dropped; no retry.
                        r_err_to <= 1'b1;
                        r_ptr    <= r_gnt_id;
                        r_state  <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!i_tx_busy) begin
                        r_ptr   <= r_gnt_id;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ack    = r_ack;
    assign o_par_data   = r_par_data;
    assign o_data_valid = r_data_valid;
    assign o_par_en     = r_par_en;
    assign o_par_typ    = r_par_typ;
    assign o_gnt_id     = r_gnt_id;
    assign o_err_to     = r_err_to;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboard of expected launches plus a BUSY model.
module tb_uart_tx_sched;

    localparam int NREQ   = 4;
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_par_en;
    logic [3:0]  req_par_typ;
    logic [3:0]  req_ack;
    logic        tx_busy;
    logic [7:0]  par_data;
    logic        data_valid;
    logic        par_en;
    logic        par_typ;
    logic [1:0]  gnt_id;
    logic        err_to;

    typedef struct {
        int       id;
        logic [7:0] data;
        logic     pe;
        logic     pt;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   ack_cycles;

    // Transmitter stand-in: BUSY high for 11 cycles after each DATA_VALID when enabled.
    bit   model_en;
    logic busy_force;
    int   model_cnt;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ   (NREQ),
        .TO_CYC (TO_CYC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_par_en  (req_par_en),
        .i_req_par_typ (req_par_typ),
        .o_req_ack     (req_ack),
        .i_tx_busy     (tx_busy),
        .o_par_data    (par_data),
        .o_data_valid  (data_valid),
        .o_par_en      (par_en),
        .o_par_typ     (par_typ),
        .o_gnt_id      (gnt_id),
        .o_err_to      (err_to)
    );

    always @(posedge clk) begin
        if (rst || !model_en) model_cnt <= 0;
        else if (data_valid)  model_cnt <= 11;
        else if (model_cnt > 0) model_cnt <= model_cnt - 1;
    end

    assign tx_busy = model_en ? (model_cnt != 0) : busy_force;

    always @(negedge clk) begin
        if (req_ack != 4'b0) ack_cycles <= ack_cycles + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_par_en  = '0;
        req_par_typ = '0;
        busy_force  = 1'b0;
        model_en    = 1'b0;
        sb.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_dv(input int budget, output bit ok, output int waited);
        waited = 0;
        while (!data_valid && waited < budget) begin
            tick;
            waited++;
        end
        ok = data_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        req_data = 32'hFFFF_FFFF;
        req_par_en = 4'b1111;
        req_par_typ = 4'b1111;
        model_en = 1'b0;
        busy_force = 1'b0;
        tick;
        tick;
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        checks++;
        if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        checks++;
        if (par_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", par_data); end
        checks++;
        if ({par_en, par_typ} !== 2'b00) begin
            errors++; $display("FAIL reset_par: got %b%b want 00", par_en, par_typ);
        end
        checks++;
        if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt: got %0d want 0", gnt_id); end
        checks++;
        if (err_to !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_to); end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single;
        bit   ok;
        int   waited;
        int   hold_bad;
        int   extra;
        exp_t e;
        do_reset;
        model_en    = 1'b1;
        req_valid   = 4'b0001;
        req_data    = 32'h0000_00A5;
        req_par_en  = 4'b0001;
        req_par_typ = 4'b0000;
        sb.push_back('{0, 8'hA5, 1'b1, 1'b0});
        wait_dv(10, ok, waited);
        checks++;
        if (!ok || waited != 1) begin
            errors++; $display("FAIL t1_latency: got dv=%b after %0d want dv=1 after 1", ok, waited);
        end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_id, par_data, par_en, par_typ} !== {2'(e.id), e.data, e.pe, e.pt}) begin
                errors++;
                $display("FAIL t1_launch: got id=%0d data=%h pe=%b pt=%b want id=%0d data=%h pe=%b pt=%b",
                         gnt_id, par_data, par_en, par_typ, e.id, e.data, e.pe, e.pt);
            end
            checks++;
            if (req_ack !== 4'(1 << e.id)) begin
                errors++; $display("FAIL t1_ack: got %b want %b", req_ack, 4'(1 << e.id));
            end
        end else sb.delete();
        // Requester withdraws and scribbles its inputs; the launched byte must not change.
        req_valid  = 4'b0000;
        req_data   = 32'hFFFF_FFFF;
        req_par_en = 4'b0000;
        hold_bad = 0;
        extra = 0;
        for (int i = 0; i < 13; i++) begin
            tick;
            if (par_data !== 8'hA5 || par_en !== 1'b1 || par_typ !== 1'b0 || gnt_id !== 2'd0)
                hold_bad++;
            if (data_valid !== 1'b0 || req_ack !== 4'b0 || err_to !== 1'b0) extra++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL t1_hold: got %0d bad cycles want 0", hold_bad); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL t1_pulse: got %0d extra strobe cycles want 0", extra); end
    endtask

    task automatic test_round_robin;
        bit         ok;
        int         waited;
        int         a0;
        int         ids[5] = '{0, 1, 2, 3, 0};
        logic [31:0] dv_bytes = 32'h4433_2211;
        logic [3:0]  pe_v = 4'b1010;
        logic [3:0]  pt_v = 4'b0110;
        exp_t        e;
        do_reset;
        model_en    = 1'b1;
        req_valid   = 4'b1111;
        req_data    = dv_bytes;
        req_par_en  = pe_v;
        req_par_typ = pt_v;
        for (int f = 0; f < 5; f++)
            sb.push_back('{ids[f], dv_bytes[8*ids[f] +: 8], pe_v[ids[f]], pt_v[ids[f]]});
        a0 = ack_cycles;
        for (int f = 0; f < 5; f++) begin
            wait_dv(40, ok, waited);
            checks++;
            if (!ok || waited != ((f == 0) ? 1 : 13)) begin
                errors++;
                $display("FAIL t2_gap%0d: got dv=%b after %0d want dv=1 after %0d",
                         f, ok, waited, (f == 0) ? 1 : 13);
            end
            if (ok && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({gnt_id, par_data, par_en, par_typ} !== {2'(e.id), e.data, e.pe, e.pt}) begin
                    errors++;
                    $display("FAIL t2_launch%0d: got id=%0d data=%h pe=%b pt=%b want id=%0d data=%h pe=%b pt=%b",
                             f, gnt_id, par_data, par_en, par_typ, e.id, e.data, e.pe, e.pt);
                end
                checks++;
                if (req_ack !== 4'(1 << e.id)) begin
                    errors++; $display("FAIL t2_ack%0d: got %b want %b", f, req_ack, 4'(1 << e.id));
                end
            end
            tick;
        end
        req_valid = 4'b0000;
        repeat (14) tick;
        checks++;
        if (ack_cycles - a0 != 5) begin
            errors++; $display("FAIL t2_ack_count: got %0d want 5", ack_cycles - a0);
        end
    endtask

    task automatic test_timeout;
        bit   ok;
        int   waited;
        int   n;
        exp_t e;
        do_reset;
        busy_force  = 1'b0;
        req_valid   = 4'b0011;
        req_data    = 32'h0000_BBAA;
        sb.push_back('{0, 8'hAA, 1'b0, 1'b0});
        wait_dv(10, ok, waited);
        checks++;
        if (!ok) begin errors++; $display("FAIL t3_first: got no DATA_VALID want launch"); end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_id, par_data} !== {2'(e.id), e.data}) begin
                errors++; $display("FAIL t3_launch0: got id=%0d data=%h want id=%0d data=%h",
                                   gnt_id, par_data, e.id, e.data);
            end
        end else sb.delete();
        tick;
        n = 0;
        while (!err_to && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (!err_to || n != TO_CYC - 1) begin
            errors++; $display("FAIL t3_err_time: got err=%b at %0d cycles after DV want err=1 at %0d",
                               err_to, n + 1, TO_CYC);
        end
        sb.push_back('{1, 8'hBB, 1'b0, 1'b0});
        tick;
        checks++;
        if (err_to !== 1'b0) begin errors++; $display("FAIL t3_err_pulse: got %b want 0", err_to); end
        wait_dv(10, ok, waited);
        checks++;
        if (!ok || waited != 0) begin
            errors++; $display("FAIL t3_relaunch: got dv=%b after %0d want dv=1 after 0", ok, waited);
        end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_id, par_data} !== {2'(e.id), e.data}) begin
                errors++; $display("FAIL t3_launch1: got id=%0d data=%h want id=%0d data=%h",
                                   gnt_id, par_data, e.id, e.data);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_busy_block;
        bit   ok;
        int   waited;
        int   early;
        exp_t e;
        do_reset;
        busy_force = 1'b1;
        req_valid  = 4'b0010;
        req_data   = 32'h0000_5A00;
        req_par_en = 4'b0010;
        sb.push_back('{1, 8'h5A, 1'b1, 1'b0});
        early = 0;
        repeat (8) begin
            tick;
            if (data_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL t4_blocked: got %0d DV cycles want 0", early); end
        busy_force = 1'b0;
        wait_dv(5, ok, waited);
        checks++;
        if (!ok || waited != 1) begin
            errors++; $display("FAIL t4_release: got dv=%b after %0d want dv=1 after 1", ok, waited);
        end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_id, par_data, par_en, req_ack} !== {2'(e.id), e.data, e.pe, 4'b0010}) begin
                errors++; $display("FAIL t4_launch: got id=%0d data=%h pe=%b ack=%b want id=%0d data=%h pe=%b ack=0010",
                                   gnt_id, par_data, par_en, req_ack, e.id, e.data, e.pe);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_frame;
        bit   ok;
        int   waited;
        exp_t e;
        do_reset;
        model_en   = 1'b1;
        req_data   = 32'h3CC3_0000;
        req_par_en = 4'b1100;
        req_valid  = 4'b0100;
        sb.push_back('{2, 8'hC3, 1'b1, 1'b0});
        wait_dv(10, ok, waited);
        req_valid = 4'b0000;
        repeat (13) tick;
        req_valid = 4'b1000;
        sb.push_back('{3, 8'h3C, 1'b1, 1'b0});
        for (int f = 0; f < 2; f++) begin
            if (f == 1) wait_dv(10, ok, waited);
            checks++;
            if (!ok) begin errors++; $display("FAIL t5_pre%0d: got no DATA_VALID want launch", f); end
            if (ok && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({gnt_id, par_data, par_en} !== {2'(e.id), e.data, e.pe}) begin
                    errors++; $display("FAIL t5_pre_launch%0d: got id=%0d data=%h want id=%0d data=%h",
                                       f, gnt_id, par_data, e.id, e.data);
                end
            end
        end
        req_valid = 4'b0000;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        checks++;
        if ({data_valid, req_ack, par_data, par_en, par_typ, gnt_id, err_to} !== 17'd0) begin
            errors++; $display("FAIL t5_rst_outputs: got dv=%b ack=%b data=%h pe=%b pt=%b id=%0d err=%b want all 0",
                               data_valid, req_ack, par_data, par_en, par_typ, gnt_id, err_to);
        end
        rst = 1'b0;
        req_valid = 4'b1111;
        sb.delete();
        sb.push_back('{0, 8'h00, 1'b0, 1'b0});
        wait_dv(10, ok, waited);
        checks++;
        if (!ok || waited != 1) begin
            errors++; $display("FAIL t5_post_latency: got dv=%b after %0d want dv=1 after 1", ok, waited);
        end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if (gnt_id !== 2'(e.id) || req_ack !== 4'b0001) begin
                errors++; $display("FAIL t5_post_grant: got id=%0d ack=%b want id=%0d ack=0001",
                                   gnt_id, req_ack, e.id);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_parity;
        bit   ok;
        int   waited;
        int   hold_bad;
        exp_t e;
        do_reset;
        model_en    = 1'b1;
        req_valid   = 4'b0100;
        req_data    = 32'h0077_0000;
        req_par_en  = 4'b1011;
        req_par_typ = 4'b0100;
        sb.push_back('{2, 8'h77, 1'b0, 1'b1});
        wait_dv(10, ok, waited);
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_launch_seen: got no DATA_VALID want launch"); end
        if (ok) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_id, par_data, par_en, par_typ} !== {2'(e.id), e.data, e.pe, e.pt}) begin
                errors++;
                $display("FAIL t6_launch: got id=%0d data=%h pe=%b pt=%b want id=%0d data=%h pe=%b pt=%b",
                         gnt_id, par_data, par_en, par_typ, e.id, e.data, e.pe, e.pt);
            end
        end
        req_valid   = 4'b0000;
        req_par_en  = 4'b1111;
        req_par_typ = 4'b0000;
        hold_bad = 0;
        for (int i = 0; i < 13; i++) begin
            tick;
            if (par_typ !== 1'b1 || par_en !== 1'b0 || par_data !== 8'h77) hold_bad++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL t6_hold: got %0d bad cycles want 0", hold_bad); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        ack_cycles  = 0;
        rst         = 1'b1;
        model_en    = 1'b0;
        busy_force  = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_par_en  = '0;
        req_par_typ = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_busy_block;
        test_reset_mid_frame;
        test_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
